// File: rtl/beat_sequencer.sv
// beat_sequencer: divides w_CLK into beats and walks the four-beat machine
// cycle S1, A1, S2, A2. It runs continuously under w_RUN, runs one cycle per
// w_STEP rising edge, and parks in HALT when a stop is decoded at the end of A2.
module beat_sequencer #(
    parameter int DIVIDE = 4
) (
    input  logic       w_CLK,
    input  logic       w_RST_n,
    input  logic       w_RUN,
    input  logic       w_STEP,
    input  logic       w_STOP,
    output logic       ready,
    output logic       w_HA,
    output logic [1:0] b_BEAT,
    output logic       w_STOPPED
);

    localparam int PW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIVIDE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    beat_q, beat_d;
    logic          ready_q, ready_d;
    logic          step_prev_q, step_prev_d;

    logic step_rise;
    logic active_q;
    logic beat_end;

    assign step_rise = w_STEP & ~step_prev_q;
    assign active_q  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign beat_end  = active_q && (presc_q == LAST);

    // Next-state, prescaler, beat and ready strobe computation.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        beat_d      = beat_q;
        step_prev_d = w_STEP;
        ready_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                beat_d  = 2'd0;
                if (w_RUN) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (beat_end) begin
                    presc_d = '0;
                    if (beat_q == 2'd3) begin
                        // End of A2: stop beats everything, then RUN/IDLE decision.
                        beat_d = 2'd0;
                        if (w_STOP) begin
                            state_d = ST_HALT;
                        end else if ((state_q == ST_RUN) && w_RUN) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_HALT: begin
                presc_d = '0;
                beat_d  = 2'd0;
                if (!w_RUN) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                beat_d  = 2'd0;
            end
        endcase

        // The strobe is registered so it lines up with the last prescaler count.
        if (((state_d == ST_RUN) || (state_d == ST_STEP)) && (presc_d == LAST)) begin
            ready_d = 1'b1;
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge w_CLK or negedge w_RST_n) begin
        if (!w_RST_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            beat_q      <= 2'd0;
            ready_q     <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            beat_q      <= beat_d;
            ready_q     <= ready_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign ready     = ready_q;
    assign b_BEAT    = beat_q;
    assign w_HA      = beat_q[0];
    assign w_STOPPED = (state_q == ST_HALT);

endmodule
